adc_capture_seq: RTL and testbench
==================================

Name: adc_capture_seq

Overview:
- Parametrised successor to the LTC2308 capture engine on DE10-Nano.
- Runs a frame of conversion slots, one per RAM address. Each slot uses one of NUM_CH 6-bit channel configs, selected round-robin.
- Each sample is written to the capture RAM by read-modify-write, in either overwrite or accumulate (averaging) mode, over num_frames passes.
- Adds busy/done/stop handshakes and single-shot or continuous operation. Sits between the HPS-visible config registers and the dual-port capture RAM.

Parameters:
- CLK_PER_SLOT, 320, clk cycles per conversion slot (tCYC = 2 us at 160 MHz).
- CONVST_HI, 6, clk cycles that CONVST is held high (must be ≥ 4).
- T_CONV, 256, clk cycles from slot start to the first SCK bit (must cover tCONV of 1.6 us).
- SCK_DIV, 4, clk cycles per SCK bit (even, ≥ 2).
- ADC_BITS, 12, sample width.
- NUM_CH, 2, number of config slots (power of two, 1..8).
- ADDR_W, 12, RAM address width.
- DATA_W, 32, RAM word width.
- Constraint: CLK_PER_SLOT ≥ T_CONV + ADC_BITS*SCK_DIV + 6.

Ports:
- clk  in  1  capture clock, 160 MHz.
- reset  in  1  synchronous, active-high.
- adc_convst  out  1  ADC conversion start.
- adc_sck  out  1  ADC serial clock.
- adc_sdi  out  1  ADC config data.
- adc_sdo  in  1  ADC sample data.
- adc_ram_addr  out  ADDR_W  RAM address.
- adc_ram_rd_data  in  DATA_W  RAM read data (1-cycle read latency).
- adc_ram_we  out  1  RAM write strobe, 1 clk.
- adc_ram_wr_data  out  DATA_W  RAM write data.
- adc_cfg  in  6*NUM_CH  packed configs; slice k drives channel slot k.
- frame_len  in  ADDR_W  number of slots per frame minus 1.
- num_frames  in  16  number of passes minus 1 (ignored when continuous=1).
- accumulate  in  1  1 = add sample to RAM word; 0 = overwrite.
- continuous  in  1  1 = repeat frames until stop.
- adc_start  in  1  1-clk start pulse.
- adc_stop  in  1  1-clk stop request.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  1-clk pulse on return to IDLE.
- frame_cnt  out  16  number of completed frames.

Behaviour:
- Reset: all outputs 0, FSM goes to IDLE, slot and address counters cleared.
- Reset mid-slot aborts immediately; adc_ram_we is low in the following cycle.
- FSM states:
  - IDLE: on adc_start, latch frame_len, num_frames, accumulate and continuous; clear addr and frame_cnt; busy=1; go to SLOT. adc_start while busy is ignored.
  - SLOT: slot counter s runs 0..CLK_PER_SLOT-1. At s = CLK_PER_SLOT-1, go to NEXT.
  - NEXT (1 clk):
    - If stop_pending, go to IDLE.
    - Else if addr < frame_len, addr+1 and go to SLOT.
    - Else (last slot of frame): frame_cnt+1, addr=0. Then, if continuous or frame_cnt < num_frames, go to SLOT; otherwise go to IDLE.
  - Entering IDLE from NEXT: done=1 for one cycle, busy=0.
- Stop handling: adc_stop sets stop_pending. The current slot, including its RAM write, always completes. stop_pending clears on entry to IDLE.
- Channel select: cfg index = addr[log2(NUM_CH)-1:0].
- adc_convst: high for s in [1, CONVST_HI], low otherwise.
- Serial transfer, for bit i = 0..ADC_BITS-1 over the window s in [T_CONV + i*SCK_DIV, T_CONV + (i+1)*SCK_DIV - 1]:
  - adc_sck is high during the second half of each bit window.
  - adc_sdi = cfg[i] for i < 6 (config bit 0 goes first, matching existing software packing); 0 otherwise and outside the window.
  - adc_sdo is sampled at the first clk of each bit window and shifted MSB-first into a sample register.
- RAM read-modify-write (adc_ram_addr is stable for the whole slot):
  - s = CLK_PER_SLOT-5: register adc_ram_rd_data.
  - s = CLK_PER_SLOT-4: adc_ram_wr_data = (accumulate && frame_cnt != 0) ? rd + zero-extended sample : zero-extended sample. The first pass therefore clears stale RAM.
  - s = CLK_PER_SLOT-3: adc_ram_we = 1 for one cycle.
- Arithmetic: accumulation wraps modulo 2^DATA_W; no saturation.
- Simultaneous adc_start and adc_stop in IDLE: the start is accepted and the stop is ignored.
- adc_stop in IDLE: ignored.

Decomposition:
- Package adc_capture_pkg: FSM state enum (IDLE, SLOT, NEXT); CFG_W=6; LTC2308 timing defaults; a clog2 helper for the channel-index width.
- Sub-module adc_spi_slot: slot counter in; generates convst/sck/sdi, owns the sample shift register, outputs sample_valid at the end of the transfer.
- Top level owns the FSM, address/frame counters and the RAM read-modify-write.

Test Plan:
- Single frame, overwrite: frame_len=3, num_frames=0, ADC model returns 0xA5A → RAM[0..3]=0x00000A5A; exactly 4 we pulses; done pulses once, 4*321 clk after start.
- Channel rotation: NUM_CH=2, adc_cfg={6'b100010, 6'b010001} → SDI on even slots shifts 1,0,0,0,1,0; on odd slots 0,1,0,0,0,1.
- Accumulate: num_frames=3, frame_len=0, sample fixed at 0xFFF, RAM preloaded with 0x12345678 → final RAM[0]=4*0xFFF=0x3FFC; frame_cnt=4.
- Stop mid-slot: continuous=1, adc_stop asserted at s=100 of addr 2 → write to addr 2 still occurs; done 1 clk after NEXT; no further CONVST.
- Timing: check CONVST high exactly at s=1..6; 12 SCK rising edges at s=T_CONV+2+4i; SDO sampled at s=T_CONV+4i.
- Reset at s=CLK_PER_SLOT-3 (we cycle) → we low next cycle; busy=0; addr=0; restart works normally.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the LTC2308 capture sequencer.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOT = 2'd1,
    ST_NEXT = 2'd2
  } state_t;

  // Width of one per-channel LTC2308 config word (S/D, O/S, S1, S0, UNI, SLP).
  localparam int unsigned CFG_W = 6;

  // LTC2308 timing at a 160 MHz capture clock.
  localparam int unsigned DEF_CLK_PER_SLOT = 320;
  localparam int unsigned DEF_CONVST_HI    = 6;
  localparam int unsigned DEF_T_CONV       = 256;
  localparam int unsigned DEF_SCK_DIV      = 4;
  localparam int unsigned DEF_ADC_BITS     = 12;

  // Bits needed to index n items; never less than 1 so vectors stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/adc_spi_slot.sv
// Per-slot LTC2308 pin sequencing: CONVST pulse, SCK/SDI generation and
// MSB-first capture of SDO, all keyed off the slot counter from the top level.
module adc_spi_slot
  import adc_capture_pkg::*;
#(
  parameter int unsigned CONVST_HI = DEF_CONVST_HI,
  parameter int unsigned T_CONV    = DEF_T_CONV,
  parameter int unsigned SCK_DIV   = DEF_SCK_DIV,
  parameter int unsigned ADC_BITS  = DEF_ADC_BITS,
  parameter int unsigned SLOT_W    = clog2(DEF_CLK_PER_SLOT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                active,
  input  logic [SLOT_W-1:0]   slot_cnt,
  input  logic [CFG_W-1:0]    cfg,
  input  logic                sdo,
  output logic                convst,
  output logic                sck,
  output logic                sdi,
  output logic [ADC_BITS-1:0] sample,
  output logic                sample_valid
);

  localparam int unsigned PH_W  = clog2(SCK_DIV);
  localparam int unsigned BIT_W = clog2(ADC_BITS);

  logic                xfer;
  logic [PH_W-1:0]     phase;
  logic [BIT_W-1:0]    bit_idx;
  logic [ADC_BITS-1:0] sdi_word;

  // Bit-window sequencer: arms one cycle before T_CONV so the first window
  // starts exactly at s = T_CONV, then walks phase/bit until the last bit.
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      xfer    <= 1'b0;
      phase   <= '0;
      bit_idx <= '0;
    end else if (slot_cnt == SLOT_W'(T_CONV - 1)) begin
      xfer    <= 1'b1;
      phase   <= '0;
      bit_idx <= '0;
    end else if (xfer) begin
      if (phase == PH_W'(SCK_DIV - 1)) begin
        phase <= '0;
        if (bit_idx == BIT_W'(ADC_BITS - 1)) xfer <= 1'b0;
        else bit_idx <= bit_idx + 1'b1;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  // Sample shift register: SDO taken on the first clk of each bit window.
  always_ff @(posedge clk) begin
    if (reset) sample <= '0;
    else if (xfer && phase == '0) sample <= {sample[ADC_BITS-2:0], sdo};
  end

  // Config bits beyond CFG_W read as zero, so SDI idles low for the tail bits.
  assign sdi_word     = ADC_BITS'(cfg);
  assign convst       = active && (slot_cnt >= SLOT_W'(1)) && (slot_cnt <= SLOT_W'(CONVST_HI));
  assign sck          = xfer && (phase >= PH_W'(SCK_DIV / 2));
  assign sdi          = xfer && sdi_word[bit_idx];
  assign sample_valid = xfer && (phase == PH_W'(SCK_DIV - 1)) && (bit_idx == BIT_W'(ADC_BITS - 1));

endmodule

// File: rtl/adc_capture_seq.sv
// Capture sequencer: runs frames of conversion slots, one per RAM address,
// and read-modify-writes each sample into the capture RAM.
module adc_capture_seq
  import adc_capture_pkg::*;
#(
  parameter int unsigned CLK_PER_SLOT = DEF_CLK_PER_SLOT,
  parameter int unsigned CONVST_HI    = DEF_CONVST_HI,
  parameter int unsigned T_CONV       = DEF_T_CONV,
  parameter int unsigned SCK_DIV      = DEF_SCK_DIV,
  parameter int unsigned ADC_BITS     = DEF_ADC_BITS,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    adc_convst,
  output logic                    adc_sck,
  output logic                    adc_sdi,
  input  logic                    adc_sdo,
  output logic [ADDR_W-1:0]       adc_ram_addr,
  input  logic [DATA_W-1:0]       adc_ram_rd_data,
  output logic                    adc_ram_we,
  output logic [DATA_W-1:0]       adc_ram_wr_data,
  input  logic [CFG_W*NUM_CH-1:0] adc_cfg,
  input  logic [ADDR_W-1:0]       frame_len,
  input  logic [15:0]             num_frames,
  input  logic                    accumulate,
  input  logic                    continuous,
  input  logic                    adc_start,
  input  logic                    adc_stop,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned SLOT_W = clog2(CLK_PER_SLOT);
  localparam int unsigned CH_W   = clog2(NUM_CH);

  state_t              state, state_nx;
  logic [SLOT_W-1:0]   slot_cnt;
  logic                slot_end;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   frame_len_q;
  logic [15:0]         num_frames_q;
  logic                accumulate_q;
  logic                continuous_q;
  logic                stop_pending;
  logic                accept, finish, adv_addr, wrap_frame;
  logic [CH_W-1:0]     ch_sel;
  logic [CFG_W-1:0]    cfg_sel;
  logic [ADC_BITS-1:0] sample, sample_q;
  logic                sample_valid;
  logic [DATA_W-1:0]   rd_q;

  assign slot_end     = (slot_cnt == SLOT_W'(CLK_PER_SLOT - 1));
  assign adc_ram_addr = addr;
  assign adc_ram_we   = (state == ST_SLOT) && (slot_cnt == SLOT_W'(CLK_PER_SLOT - 3));

  // Round-robin channel config: low address bits pick the config slice.
  always_comb begin
    ch_sel = '0;
    if (NUM_CH > 1) ch_sel = addr[CH_W-1:0];
    cfg_sel = adc_cfg[int'(ch_sel)*CFG_W +: CFG_W];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    finish     = 1'b0;
    adv_addr   = 1'b0;
    wrap_frame = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (adc_start) begin
          accept   = 1'b1;
          state_nx = ST_SLOT;
        end
      end
      ST_SLOT: begin
        if (slot_end) state_nx = ST_NEXT;
      end
      ST_NEXT: begin
        if (stop_pending) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end else if (addr < frame_len_q) begin
          adv_addr = 1'b1;
          state_nx = ST_SLOT;
        end else begin
          // frame_cnt here is still the pre-increment count of finished frames.
          wrap_frame = 1'b1;
          if (continuous_q || frame_cnt < num_frames_q) begin
            state_nx = ST_SLOT;
          end else begin
            finish   = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Slot/address/frame counters, run config latch and handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt     <= '0;
      addr         <= '0;
      frame_cnt    <= '0;
      frame_len_q  <= '0;
      num_frames_q <= '0;
      accumulate_q <= 1'b0;
      continuous_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      done <= finish;
      if (state == ST_SLOT && !slot_end) slot_cnt <= slot_cnt + 1'b1;
      else slot_cnt <= '0;

      if (accept) begin
        frame_len_q  <= frame_len;
        num_frames_q <= num_frames;
        accumulate_q <= accumulate;
        continuous_q <= continuous;
        addr         <= '0;
        frame_cnt    <= '0;
        busy         <= 1'b1;
      end else if (adv_addr) begin
        addr <= addr + 1'b1;
      end else if (wrap_frame) begin
        addr      <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end

      if (finish) busy <= 1'b0;

      // A stop only takes effect at the next NEXT, so the running slot and
      // its RAM write always complete; a stop seen in IDLE is dropped.
      if (finish || accept) stop_pending <= 1'b0;
      else if (adc_stop && state != ST_IDLE) stop_pending <= 1'b1;
    end
  end

  // RAM read-modify-write near the end of each slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q        <= '0;
      rd_q            <= '0;
      adc_ram_wr_data <= '0;
    end else begin
      if (sample_valid) sample_q <= sample;
      if (state == ST_SLOT) begin
        if (slot_cnt == SLOT_W'(CLK_PER_SLOT - 5)) rd_q <= adc_ram_rd_data;
        if (slot_cnt == SLOT_W'(CLK_PER_SLOT - 4)) begin
          // First pass overwrites so stale RAM contents never leak into a sum.
          if (accumulate_q && frame_cnt != '0) adc_ram_wr_data <= rd_q + DATA_W'(sample_q);
          else adc_ram_wr_data <= DATA_W'(sample_q);
        end
      end
    end
  end

  adc_spi_slot #(
    .CONVST_HI (CONVST_HI),
    .T_CONV    (T_CONV),
    .SCK_DIV   (SCK_DIV),
    .ADC_BITS  (ADC_BITS),
    .SLOT_W    (SLOT_W)
  ) u_spi (
    .clk          (clk),
    .reset        (reset),
    .active       (state == ST_SLOT),
    .slot_cnt     (slot_cnt),
    .cfg          (cfg_sel),
    .sdo          (adc_sdo),
    .convst       (adc_convst),
    .sck          (adc_sck),
    .sdi          (adc_sdi),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

endmodule

// File: tb/tb_adc_capture_seq.sv
// Self-checking bench for adc_capture_seq: behavioural LTC2308 and RAM models,
// write scoreboard, and directed runs for the main operating modes.
`timescale 1ns/1ps
module tb_adc_capture_seq;

  localparam int CPS = 320;
  localparam int CHI = 6;
  localparam int TC  = 256;
  localparam int SD  = 4;
  localparam int AB  = 12;
  localparam int NCH = 2;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int SLOT_CYC = CPS + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            adc_convst, adc_sck, adc_sdi, adc_sdo;
  logic [AW-1:0]   adc_ram_addr;
  logic [DW-1:0]   adc_ram_rd_data;
  logic            adc_ram_we;
  logic [DW-1:0]   adc_ram_wr_data;
  logic [6*NCH-1:0] adc_cfg;
  logic [AW-1:0]   frame_len;
  logic [15:0]     num_frames;
  logic            accumulate, continuous, adc_start, adc_stop;
  logic            busy, done;
  logic [15:0]     frame_cnt;

  adc_capture_seq #(
    .CLK_PER_SLOT (CPS),
    .CONVST_HI    (CHI),
    .T_CONV       (TC),
    .SCK_DIV      (SD),
    .ADC_BITS     (AB),
    .NUM_CH       (NCH),
    .ADDR_W       (AW),
    .DATA_W       (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .adc_convst      (adc_convst),
    .adc_sck         (adc_sck),
    .adc_sdi         (adc_sdi),
    .adc_sdo         (adc_sdo),
    .adc_ram_addr    (adc_ram_addr),
    .adc_ram_rd_data (adc_ram_rd_data),
    .adc_ram_we      (adc_ram_we),
    .adc_ram_wr_data (adc_ram_wr_data),
    .adc_cfg         (adc_cfg),
    .frame_len       (frame_len),
    .num_frames      (num_frames),
    .accumulate      (accumulate),
    .continuous      (continuous),
    .adc_start       (adc_start),
    .adc_stop        (adc_stop),
    .busy            (busy),
    .done            (done),
    .frame_cnt       (frame_cnt)
  );

  always #3 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_now = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_now++;
  endtask

  // Capture RAM: 1-cycle read latency, plus a bench-side preload port.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;
  always @(posedge clk) begin
    adc_ram_rd_data <= ram[adc_ram_addr];
    if (adc_ram_we) ram[adc_ram_addr] <= adc_ram_wr_data;
    else if (pre_en) ram[pre_a] <= pre_d;
  end

  // LTC2308 model: result loaded on CONVST, MSB out first, shifts on SCK fall.
  logic [AB-1:0] adc_val = '0;
  logic [AB-1:0] adc_sh  = '0;
  logic          sdo_ovr_en = 1'b0;
  logic          sdo_ovr    = 1'b0;
  always @(posedge adc_convst) adc_sh <= adc_val;
  always @(negedge adc_sck) adc_sh <= {adc_sh[AB-2:0], 1'b0};
  assign adc_sdo = sdo_ovr_en ? sdo_ovr : adc_sh[AB-1];

  // Write scoreboard.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];
  int   we_cnt = 0;
  int   done_cnt = 0;
  int   conv_rises = 0;

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) done_cnt++;
    if (adc_ram_we) begin
      we_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("sb_extra_we", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_addr", adc_ram_addr, e.addr);
        check_eq("sb_data", adc_ram_wr_data, e.data);
      end
    end
  end

  // SDI monitor: bits taken on SCK rise, bit k of each word is the k-th sent.
  logic [AB-1:0] sdi_q[$];
  logic [AB-1:0] sdi_vec = '0;
  int            sdi_n = 0;
  logic          p_conv = 1'b0, p_sck = 1'b0;
  always @(posedge clk) begin
    #1;
    if (adc_convst && !p_conv) begin
      conv_rises++;
      sdi_n   = 0;
      sdi_vec = '0;
    end
    if (adc_sck && !p_sck) begin
      if (sdi_n < AB) sdi_vec[sdi_n] = adc_sdi;
      sdi_n++;
      if (sdi_n == AB) sdi_q.push_back(sdi_vec);
    end
    p_conv = adc_convst;
    p_sck  = adc_sck;
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  // Returns with the DUT in its first SLOT cycle (s = 0).
  task automatic start_run(input logic [AW-1:0] flen, input logic [15:0] nfr,
                           input logic acc, input logic cont, input logic stop_too);
    frame_len  = flen;
    num_frames = nfr;
    accumulate = acc;
    continuous = cont;
    adc_start  = 1'b1;
    adc_stop   = stop_too;
    tick();
    adc_start  = 1'b0;
    adc_stop   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (!done && t < budget) begin
      tick();
      t++;
    end
    if (!done) check_eq("done_timeout", done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [AB-1:0] sdi_exp [2] = '{12'h011, 12'h022};

  initial begin
    int t0, cr, wc, dc;
    int conv_bad, sck_bad, nrise, we_k, bi, ph;
    logic psck;
    logic [AB-1:0] pat;
    logic [DW-1:0] acc_exp;

    reset      = 1'b1;
    adc_cfg    = {6'b100010, 6'b010001};
    frame_len  = '0;
    num_frames = '0;
    accumulate = 1'b0;
    continuous = 1'b0;
    adc_start  = 1'b0;
    adc_stop   = 1'b0;
    repeat (4) tick();

    // Reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_outs", {adc_convst, adc_sck, adc_sdi, adc_ram_we}, 0);
    check_eq("rst_addr", adc_ram_addr, 0);
    check_eq("rst_wdata", adc_ram_wr_data, 0);
    check_eq("rst_fcnt", frame_cnt, 0);
    reset = 1'b0;
    tick();

    // Single frame, overwrite; a start while busy must be ignored
    for (int a = 0; a < 4; a++) preload(AW'(a), 32'hDEADBEEF);
    adc_val = 12'hA5A;
    wc = we_cnt;
    dc = done_cnt;
    for (int a = 0; a < 4; a++) push_exp(AW'(a), 32'h0000_0A5A);
    start_run(3, 0, 0, 0, 0);
    t0 = cyc_now;
    repeat (500) tick();
    adc_start = 1'b1;
    tick();
    adc_start = 1'b0;
    wait_done(4 * SLOT_CYC + 50);
    check_eq("t1_done_cyc", cyc_now - t0, 4 * SLOT_CYC);
    tick();
    check_eq("t1_done_pulse", done, 0);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_done_cnt", done_cnt - dc, 1);
    check_eq("t1_we_cnt", we_cnt - wc, 4);
    for (int a = 0; a < 4; a++) check_eq("t1_ram", ram[a], 32'h0000_0A5A);
    check_eq("t1_fcnt", frame_cnt, 1);
    check_eq("t1_sb_drain", sb_q.size(), 0);

    // Channel rotation; a stop seen in IDLE must not cut the run short
    adc_stop = 1'b1;
    tick();
    adc_stop = 1'b0;
    sdi_q.delete();
    adc_val = 12'h3C5;
    for (int a = 0; a < 4; a++) push_exp(AW'(a), 32'h0000_03C5);
    start_run(3, 0, 0, 0, 0);
    wait_done(4 * SLOT_CYC + 50);
    tick();
    check_eq("t2_sdi_words", sdi_q.size(), 4);
    for (int k = 0; k < 4 && k < sdi_q.size(); k++) check_eq("t2_sdi", sdi_q[k], sdi_exp[k % 2]);
    check_eq("t2_sb_drain", sb_q.size(), 0);

    // Accumulate over 4 passes on stale RAM
    preload(0, 32'h1234_5678);
    adc_val = 12'hFFF;
    acc_exp = '0;
    for (int f = 0; f < 4; f++) begin
      acc_exp = acc_exp + 32'h0000_0FFF;
      push_exp(0, acc_exp);
    end
    start_run(0, 3, 1, 0, 0);
    t0 = cyc_now;
    wait_done(4 * SLOT_CYC + 50);
    check_eq("t3_done_cyc", cyc_now - t0, 4 * SLOT_CYC);
    tick();
    check_eq("t3_ram", ram[0], 32'h0000_3FFC);
    check_eq("t3_fcnt", frame_cnt, 4);
    check_eq("t3_sb_drain", sb_q.size(), 0);

    // Stop at s=100 of addr 2 in continuous mode
    preload(3, 32'hCAFE_0003);
    adc_val = 12'h123;
    for (int a = 0; a < 3; a++) push_exp(AW'(a), 32'h0000_0123);
    start_run(7, 0, 0, 1, 0);
    t0 = cyc_now;
    repeat (2 * SLOT_CYC + 100) tick();
    adc_stop = 1'b1;
    tick();
    adc_stop = 1'b0;
    wait_done(2 * SLOT_CYC);
    check_eq("t4_done_cyc", cyc_now - t0, 3 * SLOT_CYC);
    cr = conv_rises;
    repeat (700) tick();
    check_eq("t4_no_convst", conv_rises - cr, 0);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_ram3", ram[3], 32'hCAFE_0003);
    check_eq("t4_ram2", ram[2], 32'h0000_0123);
    check_eq("t4_sb_drain", sb_q.size(), 0);

    // Pin timing; SDO is valid only on the first clk of each bit window
    preload(0, 32'h0000_0100);
    pat = 12'h5B3;
    push_exp(0, 32'h0000_05B3);
    sdo_ovr_en = 1'b1;
    start_run(0, 0, 1, 0, 0);
    t0 = cyc_now;
    conv_bad = 0;
    sck_bad  = 0;
    nrise    = 0;
    we_k     = -1;
    psck     = adc_sck;
    for (int k = 0; k < CPS; k++) begin
      if (k >= TC && k < TC + AB * SD) begin
        bi = (k - TC) / SD;
        ph = (k - TC) % SD;
        sdo_ovr = (ph == 0) ? pat[AB-1-bi] : ~pat[AB-1-bi];
      end else begin
        sdo_ovr = 1'b1;
      end
      if (adc_convst !== (k >= 1 && k <= CHI)) conv_bad++;
      if (adc_sck && !psck) begin
        if (k != TC + 2 + SD * nrise) sck_bad++;
        nrise++;
      end
      psck = adc_sck;
      if (adc_ram_we) we_k = k;
      tick();
    end
    sdo_ovr_en = 1'b0;
    wait_done(50);
    check_eq("t5_done_cyc", cyc_now - t0, SLOT_CYC);
    tick();
    check_eq("t5_convst_win", conv_bad, 0);
    check_eq("t5_sck_rises", nrise, AB);
    check_eq("t5_sck_pos", sck_bad, 0);
    check_eq("t5_we_slot", we_k, CPS - 3);
    check_eq("t5_ram", ram[0], 32'h0000_05B3);
    check_eq("t5_sb_drain", sb_q.size(), 0);

    // Reset during the write cycle of addr 1, then a clean restart
    adc_val = 12'h777;
    push_exp(0, 32'h0000_0777);
    push_exp(1, 32'h0000_0777);
    start_run(3, 0, 0, 0, 0);
    repeat (SLOT_CYC + CPS - 3) tick();
    check_eq("t6_we_before", adc_ram_we, 1);
    check_eq("t6_addr_before", adc_ram_addr, 1);
    reset = 1'b1;
    tick();
    check_eq("t6_we_after", adc_ram_we, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_addr", adc_ram_addr, 0);
    check_eq("t6_convst", adc_convst, 0);
    reset = 1'b0;
    tick();
    check_eq("t6_sb_drain", sb_q.size(), 0);
    adc_val = 12'h2AA;
    push_exp(0, 32'h0000_02AA);
    push_exp(1, 32'h0000_02AA);
    start_run(1, 0, 0, 0, 1);
    t0 = cyc_now;
    wait_done(2 * SLOT_CYC + 50);
    check_eq("t7_done_cyc", cyc_now - t0, 2 * SLOT_CYC);
    tick();
    check_eq("t7_fcnt", frame_cnt, 1);
    check_eq("t7_sb_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
